capture_4dig_7seg: RTL and testbench

Receive-side counterpart of the 4-digit multiplexed 7-segment driver. Snoops the digit-select and active-low segment lines of a scanned display and decodes each digit back to a hex nibble. It reassembles the 16-bit displayed value, digit 3 (MSD) first. Used for board self-test and loopback: its output is compared against the driver's data input.

---
 rtl/capture_4dig_7seg_if.sv | 20 ++
 rtl/capture_4dig_7seg.sv | 119 +++++++++++
 tb/tb_capture_4dig_7seg.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/capture_4dig_7seg_if.sv
// Snoop-side bundle of a scanned 4-digit 7-segment display plus the decoded-frame results.
interface capture_4dig_7seg_if;
    logic [3:0]  xSelect;
    logic [7:0]  xSegment;
    logic [15:0] xDOutput;
    logic        xValid;
    logic        xCodeErr;
    logic        xSeqErr;
    logic        xLink;

    modport master (
        output xSelect, xSegment,
        input  xDOutput, xValid, xCodeErr, xSeqErr, xLink
    );

    modport slave (
        input  xSelect, xSegment,
        output xDOutput, xValid, xCodeErr, xSeqErr, xLink
    );
endinterface

// File: rtl/capture_4dig_7seg.sv
// Decodes a multiplexed 4-digit 7-segment scan back into the 16-bit value shown,
// checking digit order, segment codes and scan liveness.
module capture_4dig_7seg #(
    parameter int dSettle  = 4,
    parameter int dTimeout = 1000
) (
    input  logic               xClk_20kHz,
    input  logic               xRst_n,
    capture_4dig_7seg_if.slave bus
);
    localparam logic [15:0] SETTLE = 16'(dSettle);
    localparam logic [15:0] TMO    = 16'(dTimeout);

    localparam logic [1:0] EXP3 = 2'd0;
    localparam logic [1:0] EXP2 = 2'd1;
    localparam logic [1:0] EXP1 = 2'd2;
    localparam logic [1:0] EXP0 = 2'd3;

    // {select, segments a..g}; the decimal point never enters the pipeline
    logic [10:0]      s1, s2;
    logic [15:0]      stab_cnt, stab_next;
    logic [15:0]      to_cnt, to_next;
    logic [1:0]       state, exp_digit, digit;
    logic [3:0][3:0]  frame;
    logic [3:0]       err;
    logic             done, onehot, accept;
    logic [4:0]       dec;

    function automatic logic [4:0] decode(input logic [6:0] seg_n);
        logic [4:0] r;
        case (~seg_n)
            7'h7E: r = 5'h00;  7'h30: r = 5'h01;  7'h6D: r = 5'h02;  7'h79: r = 5'h03;
            7'h33: r = 5'h04;  7'h5B: r = 5'h05;  7'h5F: r = 5'h06;  7'h70: r = 5'h07;
            7'h7F: r = 5'h08;  7'h7B: r = 5'h09;  7'h77: r = 5'h0A;  7'h1F: r = 5'h0B;
            7'h4E: r = 5'h0C;  7'h3D: r = 5'h0D;  7'h4F: r = 5'h0E;  7'h47: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        onehot = 1'b1;
        digit  = 2'd0;
        case (s2[10:7])
            4'b1000: digit = 2'd3;
            4'b0100: digit = 2'd2;
            4'b0010: digit = 2'd1;
            4'b0001: digit = 2'd0;
            default: onehot = 1'b0;
        endcase
    end

    // s1 is the value s2 takes next, so s1==s2 means s2 is not about to change
    always_comb begin
        if (s1 != s2)             stab_next = '0;
        else if (stab_cnt >= SETTLE) stab_next = stab_cnt;
        else                      stab_next = stab_cnt + 16'd1;
    end

    assign accept    = onehot && (stab_next == SETTLE) && (stab_cnt != SETTLE);
    assign to_next   = accept ? '0 : ((to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1);
    assign dec       = decode(s2[6:0]);
    assign exp_digit = 2'd3 - state;

    always_ff @(posedge xClk_20kHz) begin
        if (!xRst_n) begin
            s1           <= '0;
            s2           <= '0;
            stab_cnt     <= '0;
            to_cnt       <= '0;
            state        <= EXP3;
            frame        <= '0;
            err          <= '0;
            done         <= 1'b0;
            bus.xDOutput <= '0;
            bus.xValid   <= 1'b0;
            bus.xCodeErr <= 1'b0;
            bus.xSeqErr  <= 1'b0;
            bus.xLink    <= 1'b0;
        end else begin
            s1         <= {bus.xSelect, bus.xSegment[6:0]};
            s2         <= s1;
            stab_cnt   <= stab_next;
            to_cnt     <= to_next;
            done       <= 1'b0;
            bus.xSeqErr <= 1'b0;
            bus.xValid <= done;
            if (done) begin
                bus.xDOutput <= frame;
                bus.xCodeErr <= |err;
            end
            // a completing frame wins over a simultaneous timeout
            if (done)                 bus.xLink <= 1'b1;
            else if (to_next == TMO)  bus.xLink <= 1'b0;

            if (accept) begin
                if (digit == 2'd3) begin
                    frame[3] <= dec[3:0];
                    err      <= {dec[4], 3'b000};
                    state    <= EXP2;
                end else if (state != EXP3 && digit == exp_digit) begin
                    frame[digit] <= dec[3:0];
                    err[digit]   <= dec[4];
                    case (state)
                        EXP2:    state <= EXP1;
                        EXP1:    state <= EXP0;
                        default: begin
                            state <= EXP3;
                            done  <= 1'b1;
                        end
                    endcase
                end else begin
                    bus.xSeqErr <= 1'b1;
                    state       <= EXP3;
                end
            end
        end
    end
endmodule

// File: tb/tb_capture_4dig_7seg.sv
// Random and directed scan stimulus; a queue-based display model predicts frames and order errors.
module tb_capture_4dig_7seg;
    localparam int SETTLE = 4;
    localparam int TMO    = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    capture_4dig_7seg_if bus();

    capture_4dig_7seg #(.dSettle(SETTLE), .dTimeout(TMO)) dut (
        .xClk_20kHz(clk),
        .xRst_n    (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int checks = 0, failures = 0, cyc = 0;
    int exp_seq = 0, seq_seen = 0;
    logic [16:0] exp_q [$];
    logic [16:0] e;

    // model state: next digit wanted (-1 = waiting for a digit3), current frame contents
    int         m_next = -1;
    logic [3:0] m_nib [4];
    logic       m_err [4];
    logic [10:0] last_pat = '0;
    int         run = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input int d, input logic [6:0] segn);
        logic [3:0] n = 4'h0;
        logic       er = 1'b1;
        for (int k = 0; k < 16; k++)
            if (seg_tab[k] == ~segn) begin n = 4'(k); er = 1'b0; end
        if (d == 3) begin
            m_nib[3] = n; m_err[3] = er; m_next = 2;
        end else if (m_next == d) begin
            m_nib[d] = n; m_err[d] = er;
            if (d == 0) begin
                exp_q.push_back({m_err[3] | m_err[2] | m_err[1] | m_err[0],
                                 m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
                m_next = -1;
            end else m_next = d - 1;
        end else begin
            exp_seq++;
            m_next = -1;
        end
    endtask

    // a pattern counts once it has been presented for SETTLE+1 consecutive cycles
    task automatic drive(input logic [3:0] sel, input logic [6:0] segn, input int len);
        logic [10:0] p = {sel, segn};
        for (int i = 0; i < len; i++) begin
            bus.xSelect  = sel;
            bus.xSegment = {1'($urandom), segn};
            if (p != last_pat) begin last_pat = p; run = 0; end
            run++;
            if (run == SETTLE + 1)
                case (sel)
                    4'b1000: model_accept(3, segn);
                    4'b0100: model_accept(2, segn);
                    4'b0010: model_accept(1, segn);
                    4'b0001: model_accept(0, segn);
                    default: ;
                endcase
            @(negedge clk);
        end
    endtask

    task automatic digit(input int d, input logic [3:0] nib, input int dl);
        drive(4'(1 << d), ~seg_tab[nib], dl);
    endtask

    task automatic frame(input logic [15:0] v, input int dl, input int bad, input logic [6:0] bad_sn,
                         input int skip, input int glitch);
        for (int d = 3; d >= 0; d--) begin
            logic [6:0] sn;
            logic [3:0] sel;
            if (d == skip) continue;
            sel = 4'(1 << d);
            sn  = ~seg_tab[v[d*4 +: 4]];
            if (d == bad) sn = bad_sn;
            if (d == glitch) begin
                drive(sel, sn, dl / 2);
                drive(4'b0001, ~seg_tab[0], 2);
                drive(sel, sn, dl - dl / 2);
            end else drive(sel, sn, dl);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.xValid && bus.xSeqErr) chk("valid_seqerr_exclusive", 1, 0);
            if (bus.xSeqErr) seq_seen++;
            if (bus.xValid) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("frame_value", bus.xDOutput, e[15:0]);
                    chk("frame_codeerr", bus.xCodeErr, e[16]);
                    chk("link_on_frame", bus.xLink, 1);
                end
            end
        end
    end

    initial begin
        int t0;
        bit fell;
        bus.xSelect  = 4'h0;
        bus.xSegment = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_dout", bus.xDOutput, 0);
        chk("rst_valid", bus.xValid, 0);
        chk("rst_codeerr", bus.xCodeErr, 0);
        chk("rst_seqerr", bus.xSeqErr, 0);
        chk("rst_link", bus.xLink, 0);
        rst_n = 1'b1;
        drive(4'h0, 7'h7F, 20);

        repeat (4) frame(16'h1234, 100, -1, 7'h0, -1, -1);
        repeat (2) frame(16'hABCF, 100, -1, 7'h0, -1, -1);
        digit(3, 4'hA, 100); digit(2, 4'hB, 100);
        digit(1, 4'h0, 100); digit(0, 4'h9, 100);
        repeat (2) frame(16'h0009, 100, -1, 7'h0, -1, -1);
        frame(16'h5678, 40, 2, 7'h7F, -1, -1);
        frame(16'h5678, 40, -1, 7'h0, -1, -1);
        digit(3, 4'h1, 30); digit(1, 4'h3, 30);
        frame(16'h1234, 30, -1, 7'h0, -1, -1);
        frame(16'hC0DE, 30, -1, 7'h0, -1, 3);
        frame(16'h4321, SETTLE + 1, -1, 7'h0, -1, -1);
        frame(16'h8888, SETTLE, -1, 7'h0, -1, -1);
        frame(16'h2468, 25, -1, 7'h0, -1, -1);

        for (int r = 0; r < 30; r++) begin
            int mode = $urandom % 8;
            int dl   = $urandom_range(3, 40);
            int dsel = $urandom % 4;
            if (mode == 3) drive(($urandom % 2) ? 4'b0011 : 4'b0000, 7'($urandom), $urandom_range(1, 12));
            frame(16'($urandom), dl, (mode == 2) ? dsel : -1, 7'($urandom),
                  (mode == 0) ? dsel : -1, (mode == 1) ? dsel : -1);
        end

        frame(16'h1234, 20, -1, 7'h0, -1, -1);
        t0 = cyc;
        fell = 0;
        for (int i = 0; i < TMO + 100; i++) begin
            drive(4'b1000, ~seg_tab[1], 1);
            if (!bus.xLink) begin fell = 1; break; end
        end
        chk("link_fell", fell, 1);
        chk("link_fall_cycle", cyc, t0 + 2 + SETTLE + TMO);
        chk("dout_hold", bus.xDOutput, 16'h1234);
        chk("codeerr_hold", bus.xCodeErr, 0);

        rst_n = 1'b0;
        m_next = -1;
        drive(4'h0, 7'h7F, 1);
        chk("rst2_dout", bus.xDOutput, 0);
        chk("rst2_link", bus.xLink, 0);
        chk("rst2_valid", bus.xValid, 0);
        rst_n = 1'b1;
        frame(16'hBEEF, 20, -1, 7'h0, -1, -1);
        drive(4'h0, 7'h7F, 10);

        chk("pending_frames", exp_q.size(), 0);
        chk("seqerr_count", seq_seen, exp_seq);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
